// File: rtl/fnd_scan_rx_pkg.sv
// Shared constants for the 7-segment scan receiver: segment patterns,
// special digit codes, FSM encoding and the digit-pair arithmetic helper.
package fnd_scan_rx_pkg;

   localparam int NUM_DIG = 6;

   // Active-high {a,b,c,d,e,f,g} patterns
   localparam logic [6:0] SEG_0     = 7'b1111110;
   localparam logic [6:0] SEG_1     = 7'b0110000;
   localparam logic [6:0] SEG_2     = 7'b1101101;
   localparam logic [6:0] SEG_3     = 7'b1111001;
   localparam logic [6:0] SEG_4     = 7'b0110011;
   localparam logic [6:0] SEG_5     = 7'b1011011;
   localparam logic [6:0] SEG_6     = 7'b1011111;
   localparam logic [6:0] SEG_7     = 7'b1110000;
   localparam logic [6:0] SEG_8     = 7'b1111111;
   localparam logic [6:0] SEG_9     = 7'b1110011;
   localparam logic [6:0] SEG_BLANK = 7'b0000000;

   localparam logic [3:0] CODE_BLANK   = 4'hA;
   localparam logic [3:0] CODE_ILLEGAL = 4'hF;

   typedef enum logic {
      ST_HUNT    = 1'b0,
      ST_COLLECT = 1'b1
   } state_e;

   // One registered sample of the display pins
   typedef struct packed {
      logic [5:0] enb;
      logic [6:0] seg;
      logic       dp;
   } smp_t;

   // tens*10+ones, non-numeric codes count as 0, saturated at 63
   function automatic logic [5:0] pair_val(input logic [3:0] tens, input logic [3:0] ones);
      logic [7:0] t;
      logic [7:0] o;
      logic [7:0] s;
      t = (tens <= 4'd9) ? {4'd0, tens} : 8'd0;
      o = (ones <= 4'd9) ? {4'd0, ones} : 8'd0;
      s = t * 8'd10 + o;
      return (s > 8'd63) ? 6'd63 : s[5:0];
   endfunction

endpackage

// File: rtl/fnd_enc.sv
// Combinational 7-segment pattern to digit code decoder.
// Digits 0..9 map to their value, all-off to BLANK, anything else to ILLEGAL.
module fnd_enc
   import fnd_scan_rx_pkg::*;
(
   input  logic [6:0] i_seg,
   output logic [3:0] o_code
);

   // Pattern lookup
   always_comb begin
      o_code = CODE_ILLEGAL;
      case (i_seg)
         SEG_0:     o_code = 4'd0;
         SEG_1:     o_code = 4'd1;
         SEG_2:     o_code = 4'd2;
         SEG_3:     o_code = 4'd3;
         SEG_4:     o_code = 4'd4;
         SEG_5:     o_code = 4'd5;
         SEG_6:     o_code = 4'd6;
         SEG_7:     o_code = 4'd7;
         SEG_8:     o_code = 4'd8;
         SEG_9:     o_code = 4'd9;
         SEG_BLANK: o_code = CODE_BLANK;
         default:   o_code = CODE_ILLEGAL;
      endcase
   end

endmodule

// File: rtl/fnd_scan_rx.sv
// Multiplexed 7-segment display snooper. Samples the scan pins, waits for
// each digit to dwell stably, captures it, assembles digits 0..5 in order
// and publishes a whole frame (codes, dp, mm/ss binary) at once.
module fnd_scan_rx
   import fnd_scan_rx_pkg::*;
#(
   parameter int STABLE_CYC = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [5:0]  i_seg_enb,
   input  logic [6:0]  i_seg,
   input  logic        i_seg_dp,
   output logic [23:0] o_digits,
   output logic [5:0]  o_dp,
   output logic [5:0]  o_min,
   output logic [5:0]  o_sec,
   output logic        o_frame_vld,
   output logic        o_frame_err,
   output logic        o_seq_err
);

   localparam logic [7:0] STB = 8'(STABLE_CYC);

   smp_t             smp_d, smp_q;
   logic             chg;
   logic [7:0]       cnt_d, cnt_q;
   logic             dwell_done;
   logic [2:0]       n_zero;
   logic [2:0]       idx;
   logic             cap, multi;
   logic [3:0]       cap_code;

   state_e           st_d, st_q;
   logic [2:0]       exp_d, exp_q;
   logic             wr_en, pub_d, ord_err;
   logic             pub_q;

   logic [5:0][3:0]  buf_q;
   logic [5:0]       dpbuf_q;
   logic             any_ill;

   logic [23:0]      digits_q;
   logic [5:0]       dp_q, min_q, sec_q;
   logic             vld_q, ferr_q, seq_q;

   // The counter compares the incoming sample with the held one, so it
   // restarts on the same edge the sampled value changes.
   assign smp_d      = {i_seg_enb, i_seg, i_seg_dp};
   assign chg        = (smp_d != smp_q);
   assign cnt_d      = chg ? 8'd0 : ((cnt_q == STB) ? cnt_q : cnt_q + 8'd1);
   assign dwell_done = !chg && (cnt_q == STB - 8'd1);

   // Sample stage and stability counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         smp_q <= '{enb: 6'h3F, seg: 7'd0, dp: 1'b0};
         cnt_q <= 8'd0;
      end else begin
         smp_q <= smp_d;
         cnt_q <= cnt_d;
      end
   end

   // Count active-low enables and locate the selected digit
   always_comb begin
      n_zero = 3'd0;
      idx    = 3'd0;
      for (int k = 0; k < NUM_DIG; k++) begin
         if (!smp_q.enb[k]) begin
            n_zero = n_zero + 3'd1;
            idx    = 3'(k);
         end
      end
   end

   // All-ones enable is the display blanking interval: neither capture nor error
   assign cap   = dwell_done && (n_zero == 3'd1);
   assign multi = dwell_done && (n_zero >= 3'd2);

   fnd_enc u_enc (
      .i_seg  (smp_q.seg),
      .o_code (cap_code)
   );

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st_q  <= ST_HUNT;
         exp_q <= 3'd0;
      end else begin
         st_q  <= st_d;
         exp_q <= exp_d;
      end
   end

   // FSM next state: an out-of-order digit 0 restarts the frame at once
   always_comb begin
      st_d  = st_q;
      exp_d = exp_q;
      if (cap) begin
         case (st_q)
            ST_HUNT: begin
               if (idx == 3'd0) begin
                  st_d  = ST_COLLECT;
                  exp_d = 3'd1;
               end
            end
            ST_COLLECT: begin
               if (idx == exp_q) begin
                  if (idx == 3'd5) begin
                     st_d  = ST_HUNT;
                     exp_d = 3'd0;
                  end else begin
                     exp_d = exp_q + 3'd1;
                  end
               end else if (idx == 3'd0) begin
                  st_d  = ST_COLLECT;
                  exp_d = 3'd1;
               end else begin
                  st_d  = ST_HUNT;
                  exp_d = 3'd0;
               end
            end
            default: begin
               st_d  = ST_HUNT;
               exp_d = 3'd0;
            end
         endcase
      end
   end

   // FSM outputs: buffer write, publish request, order error
   always_comb begin
      wr_en   = 1'b0;
      pub_d   = 1'b0;
      ord_err = 1'b0;
      if (cap) begin
         case (st_q)
            ST_HUNT: wr_en = (idx == 3'd0);
            ST_COLLECT: begin
               if (idx == exp_q) begin
                  wr_en = 1'b1;
                  pub_d = (idx == 3'd5);
               end else begin
                  ord_err = 1'b1;
                  wr_en   = (idx == 3'd0);
               end
            end
            default: ;
         endcase
      end
   end

   // Frame assembly buffer, plus one-cycle publish request
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         buf_q   <= {NUM_DIG{CODE_BLANK}};
         dpbuf_q <= 6'd0;
         pub_q   <= 1'b0;
      end else begin
         pub_q <= pub_d;
         if (wr_en) begin
            buf_q[idx]   <= cap_code;
            dpbuf_q[idx] <= smp_q.dp;
         end
      end
   end

   // Illegal-code scan across the assembled frame
   always_comb begin
      any_ill = 1'b0;
      for (int k = 0; k < NUM_DIG; k++)
         if (buf_q[k] == CODE_ILLEGAL) any_ill = 1'b1;
   end

   // Published outputs change only on a completed frame; seq error is sticky
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         digits_q <= 24'hAAAAAA;
         dp_q     <= 6'd0;
         min_q    <= 6'd0;
         sec_q    <= 6'd0;
         ferr_q   <= 1'b0;
         vld_q    <= 1'b0;
         seq_q    <= 1'b0;
      end else begin
         vld_q <= pub_q;
         seq_q <= seq_q | ord_err | multi;
         if (pub_q) begin
            digits_q <= buf_q;
            dp_q     <= dpbuf_q;
            min_q    <= pair_val(buf_q[3], buf_q[2]);
            sec_q    <= pair_val(buf_q[1], buf_q[0]);
            ferr_q   <= any_ill;
         end
      end
   end

   assign o_digits    = digits_q;
   assign o_dp        = dp_q;
   assign o_min       = min_q;
   assign o_sec       = sec_q;
   assign o_frame_vld = vld_q;
   assign o_frame_err = ferr_q;
   assign o_seq_err   = seq_q;

endmodule
